// File: rtl/exc_detect.sv
// exc_detect -- MEM-stage exception arbiter feeding the CP0 register file.
//
// Collects the MEM instruction's exception flags, pending hardware interrupts
// (cause IP bits) and the count/compare timer event, and picks one by priority:
// interrupt > syscall > invalid instruction > overflow > eret.
// The winner's code and PC go to CP0, and a flush plus redirect PC go to the
// pipeline in the same cycle. A small FSM holds the flush for FLUSH_CYCLES
// cycles and tracks whether we are inside a handler (EXL equivalent).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mem_valid_i          real instruction in MEM (0 = bubble)
//   mem_exc_flags_i      bit8 syscall, bit9 invalid, bit11 overflow, bit12 eret
//   mem_pc_i             PC of the MEM instruction
//   cp0_cause_i/epc_i/count_i/compare_i   CP0 register values
//   wb_cp0_we_i/waddr_i/wdata_i           WB-stage CP0 write (forwarded)
//   excepttype_o         exception code to CP0 (0 = none)
//   current_pc_o         faulting PC to CP0
//   flush_o, new_pc_o    pipeline flush and redirect PC
//   timer_int_o          latched timer interrupt
//   in_handler_o         handler-level flag
module exc_detect #(
  parameter logic [31:0] EXC_VECTOR       = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES     = 1,
  parameter logic [4:0]  CP0_COMPARE_ADDR = 5'd11,
  parameter logic [4:0]  CP0_CAUSE_ADDR   = 5'd13,
  parameter logic [4:0]  CP0_EPC_ADDR     = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_exc_flags_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_count_i,
  input  logic [31:0] cp0_compare_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_pc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        timer_int_o,
  output logic        in_handler_o
);

  localparam logic [31:0] CODE_INT     = 32'h1;
  localparam logic [31:0] CODE_SYSCALL = 32'h8;
  localparam logic [31:0] CODE_INVALID = 32'ha;
  localparam logic [31:0] CODE_OVF     = 32'hc;
  localparam logic [31:0] CODE_ERET    = 32'he;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] held_pc_q;
  logic        timer_q;
  logic        timer_d;
  logic        in_handler_q;

  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic [31:0] eff_compare;
  logic        cmp_write;
  logic        timer_set;
  logic        int_pending;
  logic [31:0] exc_code;
  logic        detect;
  logic        is_eret;
  logic [31:0] redirect_pc;

  // WB-stage CP0 writes land one cycle late, so forward them here.
  assign eff_cause   = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE_ADDR)   ? wb_cp0_wdata_i : cp0_cause_i;
  assign eff_epc     = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC_ADDR)     ? wb_cp0_wdata_i : cp0_epc_i;
  assign eff_compare = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_COMPARE_ADDR) ? wb_cp0_wdata_i : cp0_compare_i;

  assign cmp_write   = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_COMPARE_ADDR);
  assign timer_set   = (eff_compare != 32'h0) && (cp0_count_i == eff_compare);
  // A compare write acknowledges the timer and beats a coincident match.
  assign timer_d     = cmp_write ? 1'b0 : (timer_set ? 1'b1 : timer_q);

  assign int_pending = ((eff_cause[15:10] != 6'h0) || timer_q) && !in_handler_q;

  always_comb begin
    exc_code = 32'h0;
    if (state_q == S_IDLE && mem_valid_i) begin
      if (int_pending)              exc_code = CODE_INT;
      else if (mem_exc_flags_i[8])  exc_code = CODE_SYSCALL;
      else if (mem_exc_flags_i[9])  exc_code = CODE_INVALID;
      else if (mem_exc_flags_i[11]) exc_code = CODE_OVF;
      else if (mem_exc_flags_i[12]) exc_code = CODE_ERET;
    end
  end

  assign detect      = (exc_code != 32'h0);
  assign is_eret     = (exc_code == CODE_ERET);
  assign redirect_pc = is_eret ? eff_epc : EXC_VECTOR;

  always_comb begin
    current_pc_o = mem_pc_i;
    if (state_q == S_FLUSH) begin
      excepttype_o = 32'h0;
      flush_o      = 1'b1;
      new_pc_o     = held_pc_q;
    end else begin
      excepttype_o = exc_code;
      flush_o      = detect;
      new_pc_o     = detect ? redirect_pc : 32'h0;
    end
  end

  assign timer_int_o  = timer_q;
  assign in_handler_o = in_handler_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'h0;
      held_pc_q    <= 32'h0;
      timer_q      <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      case (state_q)
        S_IDLE: begin
          if (detect) begin
            in_handler_q <= !is_eret;
            // The detect cycle is the first flush cycle; only longer flushes
            // need the FLUSH state.
            if (FLUSH_CYCLES > 1) begin
              state_q   <= S_FLUSH;
              cnt_q     <= FLUSH_LOAD;
              held_pc_q <= redirect_pc;
            end
          end
        end
        S_FLUSH: begin
          cnt_q <= cnt_q - 4'h1;
          if (cnt_q == 4'h1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Flag and cause bits that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{mem_exc_flags_i[31:13], mem_exc_flags_i[10], mem_exc_flags_i[7:0],
                         eff_cause[31:16], eff_cause[9:0]};

endmodule

// File: tb/tb_exc_detect.sv
module tb_exc_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_flags;
  logic [31:0] mem_pc;
  logic [31:0] cp0_cause, cp0_epc, cp0_count, cp0_compare;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  logic [31:0] o1_et, o1_cp, o1_np;
  logic        o1_fl, o1_ti, o1_ih;
  logic [31:0] o3_et, o3_cp, o3_np;
  logic        o3_fl, o3_ti, o3_ih;

  always #5 clk = ~clk;

  exc_detect #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_exc_flags_i(mem_flags),
    .mem_pc_i(mem_pc), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
    .cp0_count_i(cp0_count), .cp0_compare_i(cp0_compare), .wb_cp0_we_i(wb_we),
    .wb_cp0_waddr_i(wb_waddr), .wb_cp0_wdata_i(wb_wdata), .excepttype_o(o1_et),
    .current_pc_o(o1_cp), .flush_o(o1_fl), .new_pc_o(o1_np), .timer_int_o(o1_ti),
    .in_handler_o(o1_ih)
  );

  exc_detect #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_exc_flags_i(mem_flags),
    .mem_pc_i(mem_pc), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
    .cp0_count_i(cp0_count), .cp0_compare_i(cp0_compare), .wb_cp0_we_i(wb_we),
    .wb_cp0_waddr_i(wb_waddr), .wb_cp0_wdata_i(wb_wdata), .excepttype_o(o3_et),
    .current_pc_o(o3_cp), .flush_o(o3_fl), .new_pc_o(o3_np), .timer_int_o(o3_ti),
    .in_handler_o(o3_ih)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance (index 0: 1-cycle flush, 1: 3-cycle flush).
  int          fc[2] = '{1, 3};
  bit          m_timer[2];
  bit          m_inh[2];
  int          m_left[2];   // remaining flush cycles after the detect cycle
  logic [31:0] m_held[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] reg_val);
    return (wb_we && wb_waddr == addr) ? wb_wdata : reg_val;
  endfunction

  // What instance k should present this cycle: exception code and redirect PC.
  task automatic model_comb(input int k, output logic [31:0] code, output logic [31:0] npc);
    logic [31:0] cause;
    bit irq;
    cause = fwd(5'd13, cp0_cause);
    code = 32'h0;
    npc  = 32'h0;
    if (m_left[k] > 0) begin
      npc = m_held[k];
      return;
    end
    if (!mem_valid) return;
    irq = ((cause[15:10] != 6'h0) || m_timer[k]) && !m_inh[k];
    if (irq)               code = 32'h1;
    else if (mem_flags[8])  code = 32'h8;
    else if (mem_flags[9])  code = 32'ha;
    else if (mem_flags[11]) code = 32'hc;
    else if (mem_flags[12]) code = 32'he;
    if (code != 32'h0) npc = (code == 32'he) ? fwd(5'd14, cp0_epc) : 32'h20;
  endtask

  task automatic compare_model();
    logic [31:0] code, npc, et, cp, np;
    logic fl, ti, ih;
    for (int k = 0; k < 2; k++) begin
      model_comb(k, code, npc);
      if (k == 0) begin et = o1_et; cp = o1_cp; np = o1_np; fl = o1_fl; ti = o1_ti; ih = o1_ih; end
      else        begin et = o3_et; cp = o3_cp; np = o3_np; fl = o3_fl; ti = o3_ti; ih = o3_ih; end
      check($sformatf("fc%0d.excepttype", fc[k]), et, code);
      check($sformatf("fc%0d.current_pc", fc[k]), cp, mem_pc);
      check($sformatf("fc%0d.flush", fc[k]), 32'(fl), 32'((m_left[k] > 0) || (code != 32'h0)));
      check($sformatf("fc%0d.new_pc", fc[k]), np, npc);
      check($sformatf("fc%0d.timer_int", fc[k]), 32'(ti), 32'(m_timer[k]));
      check($sformatf("fc%0d.in_handler", fc[k]), 32'(ih), 32'(m_inh[k]));
    end
  endtask

  task automatic model_update();
    logic [31:0] code, npc, effc;
    for (int k = 0; k < 2; k++) begin
      model_comb(k, code, npc);
      if (rst) begin
        m_timer[k] = 0; m_inh[k] = 0; m_left[k] = 0; m_held[k] = 32'h0;
      end else begin
        effc = fwd(5'd11, cp0_compare);
        if (wb_we && wb_waddr == 5'd11)               m_timer[k] = 0;
        else if (effc != 32'h0 && cp0_count == effc) m_timer[k] = 1;
        if (m_left[k] > 0) m_left[k]--;
        else if (code != 32'h0) begin
          m_inh[k] = (code != 32'he);
          if (fc[k] > 1) begin
            m_left[k] = fc[k] - 1;
            m_held[k] = npc;
          end
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input string name);
    $display("[%0t] %s", $time, name);
    settle();
    advance();
  endtask

  task automatic quiet();
    mem_valid = 0; mem_flags = 0; mem_pc = 0;
    cp0_cause = 0; cp0_epc = 0; cp0_count = 0; cp0_compare = 0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  initial begin
    quiet();
    rst = 1;
    advance();
    advance();
    rst = 0;

    // Reset state.
    $display("[%0t] reset state", $time);
    settle();
    check("rst.excepttype", o3_et, 32'h0);
    check("rst.flush", 32'(o3_fl), 32'h0);
    check("rst.new_pc", o3_np, 32'h0);
    check("rst.timer", 32'(o1_ti), 32'h0);
    check("rst.in_handler", 32'(o1_ih), 32'h0);
    advance();

    // Syscall.
    mem_valid = 1; mem_flags = 32'h100; mem_pc = 32'h100;
    $display("[%0t] syscall pc=100", $time);
    settle();
    check("sys.excepttype", o1_et, 32'h8);
    check("sys.current_pc", o1_cp, 32'h100);
    check("sys.flush", 32'(o1_fl), 32'h1);
    check("sys.new_pc", o1_np, 32'h20);
    advance();
    quiet();
    settle();
    check("sys.in_handler", 32'(o1_ih), 32'h1);
    advance();
    cyc("idle");

    // Eret inside handler with EPC forwarded from WB.
    mem_valid = 1; mem_flags = 32'h1000; mem_pc = 32'h180; cp0_epc = 32'h300;
    wb_we = 1; wb_waddr = 5'd14; wb_wdata = 32'h400;
    $display("[%0t] eret with forwarded epc", $time);
    settle();
    check("eret.excepttype", o1_et, 32'he);
    check("eret.new_pc", o1_np, 32'h400);
    advance();
    quiet();
    settle();
    check("eret.in_handler", 32'(o1_ih), 32'h0);
    advance();
    cyc("idle");

    // Interrupt beats invalid instruction, then is masked in the handler.
    mem_valid = 1; mem_flags = 32'h200; mem_pc = 32'h200; cp0_cause = 32'h400;
    $display("[%0t] interrupt vs invalid", $time);
    settle();
    check("irq.excepttype", o1_et, 32'h1);
    advance();
    mem_valid = 0; mem_flags = 0;
    cyc("idle irq held");
    cyc("idle irq held");
    mem_valid = 1; mem_pc = 32'h204;
    $display("[%0t] masked irq", $time);
    settle();
    check("irqmask.excepttype", o1_et, 32'h0);
    check("irqmask.flush", 32'(o1_fl), 32'h0);
    advance();
    cp0_cause = 0; mem_flags = 32'h1000; cp0_epc = 32'h210;
    cyc("eret leave handler");
    quiet();
    cyc("idle");
    cyc("idle");

    // Timer latch, compare-write clear, coincident set/clear.
    cp0_compare = 5; cp0_count = 4;
    cyc("count 4");
    cp0_count = 5;
    cyc("count 5");
    cp0_count = 6;
    settle();
    check("timer.set", 32'(o1_ti), 32'h1);
    advance();
    wb_we = 1; wb_waddr = 5'd11; wb_wdata = 9; cp0_count = 7;
    cyc("write compare 9");
    wb_we = 0; cp0_compare = 9; cp0_count = 8;
    settle();
    check("timer.clear", 32'(o1_ti), 32'h0);
    advance();
    wb_we = 1; wb_waddr = 5'd11; wb_wdata = 12; cp0_count = 12;
    cyc("write compare 12 coincident");
    wb_we = 0; cp0_compare = 12; cp0_count = 13;
    settle();
    check("timer.coincident", 32'(o1_ti), 32'h0);
    advance();
    quiet();

    // Three-cycle flush; overflow during the hold is ignored.
    mem_valid = 1; mem_flags = 32'h100; mem_pc = 32'h500;
    $display("[%0t] syscall pc=500 long flush", $time);
    settle();
    check("fl3.c1.excepttype", o3_et, 32'h8);
    check("fl3.c1.flush", 32'(o3_fl), 32'h1);
    check("fl3.c1.new_pc", o3_np, 32'h20);
    advance();
    mem_flags = 32'h800; mem_pc = 32'h504;
    settle();
    check("fl3.c2.excepttype", o3_et, 32'h0);
    check("fl3.c2.flush", 32'(o3_fl), 32'h1);
    check("fl3.c2.new_pc", o3_np, 32'h20);
    advance();
    quiet();
    settle();
    check("fl3.c3.flush", 32'(o3_fl), 32'h1);
    check("fl3.c3.new_pc", o3_np, 32'h20);
    advance();
    settle();
    check("fl3.c4.flush", 32'(o3_fl), 32'h0);
    advance();
    mem_valid = 1; mem_flags = 32'h1000; cp0_epc = 32'h600;
    cyc("eret leave handler");
    quiet();
    cyc("idle");
    cyc("idle");

    // Reset in the middle of a long flush.
    cp0_compare = 7; cp0_count = 7;
    cyc("timer set");
    cp0_count = 8; mem_valid = 1; mem_flags = 32'h100; mem_pc = 32'h700;
    $display("[%0t] timer irq then reset mid-flush", $time);
    settle();
    check("rstfl.excepttype", o3_et, 32'h1);
    advance();
    quiet();
    rst = 1;
    cyc("reset asserted in flush");
    rst = 0;
    settle();
    check("rstfl.flush", 32'(o3_fl), 32'h0);
    check("rstfl.timer", 32'(o3_ti), 32'h0);
    check("rstfl.in_handler", 32'(o3_ih), 32'h0);
    advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_flags = $urandom & ~32'h0000_1b00;
      if ($urandom_range(0, 7) == 0) mem_flags[8]  = 1'b1;
      if ($urandom_range(0, 7) == 0) mem_flags[9]  = 1'b1;
      if ($urandom_range(0, 7) == 0) mem_flags[11] = 1'b1;
      if ($urandom_range(0, 5) == 0) mem_flags[12] = 1'b1;
      mem_pc      = $urandom;
      cp0_cause   = $urandom & ~32'h0000_fc00;
      if ($urandom_range(0, 7) == 0) cp0_cause[10 + $urandom_range(0, 5)] = 1'b1;
      cp0_epc     = $urandom;
      cp0_count   = 32'($urandom_range(0, 7));
      cp0_compare = 32'($urandom_range(0, 7));
      wb_we       = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: wb_waddr = 5'd11;
        1: wb_waddr = 5'd13;
        2: wb_waddr = 5'd14;
        default: wb_waddr = 5'($urandom);
      endcase
      wb_wdata = (wb_waddr == 5'd11) ? 32'($urandom_range(0, 7)) : $urandom;
      $display("[%0t] rand %0d rst=%0b v=%0b flags=%h cnt=%0d cmp=%0d we=%0b wa=%0d",
               $time, i, rst, mem_valid, mem_flags[12:8], cp0_count, cp0_compare, wb_we, wb_waddr);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
